// File: rtl/fme_refine_ctrl_if.sv
// fme_refine_ctrl_if: bus bundle between the FME refinement controller and its IME source,
// SATD engine, cost block and downstream consumer. Signal suffixes are from the controller's view.
// Ports (grouped):
//   IME partition in : blk_valid_i, blk_ready_o, blk_mv_{x,y}_i, blk_mvp_{x,y}_i
//   SATD/cost block  : satd_start_o, satd_done_i, half_o, mv_{x,y}_o, mvp_{x,y}_o,
//                      cost_valid_i, bcost_i, bcand_{x,y}_i
//   Result out       : res_valid_o, res_ready_i, res_mv_{x,y}_o, res_cost_o
//   Status           : blk_idx_o, err_o
// Modports: slave = controller, master = surrounding environment.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif
interface fme_refine_ctrl_if #(
    parameter int FMVD_LEN  = 8,
    parameter int SATD_BITS = `BIT_DEPTH + 10
);
    logic                 blk_valid_i;
    logic                 blk_ready_o;
    logic [FMVD_LEN-1:0]  blk_mv_x_i;
    logic [FMVD_LEN-1:0]  blk_mv_y_i;
    logic [FMVD_LEN-1:0]  blk_mvp_x_i;
    logic [FMVD_LEN-1:0]  blk_mvp_y_i;
    logic                 satd_start_o;
    logic                 satd_done_i;
    logic                 half_o;
    logic [FMVD_LEN-1:0]  mv_x_o;
    logic [FMVD_LEN-1:0]  mv_y_o;
    logic [FMVD_LEN-1:0]  mvp_x_o;
    logic [FMVD_LEN-1:0]  mvp_y_o;
    logic                 cost_valid_i;
    logic [SATD_BITS:0]   bcost_i;
    logic [1:0]           bcand_x_i;
    logic [1:0]           bcand_y_i;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [FMVD_LEN-1:0]  res_mv_x_o;
    logic [FMVD_LEN-1:0]  res_mv_y_o;
    logic [SATD_BITS:0]   res_cost_o;
    logic [3:0]           blk_idx_o;
    logic                 err_o;

    modport slave (
        input  blk_valid_i, blk_mv_x_i, blk_mv_y_i, blk_mvp_x_i, blk_mvp_y_i,
               satd_done_i, cost_valid_i, bcost_i, bcand_x_i, bcand_y_i, res_ready_i,
        output blk_ready_o, satd_start_o, half_o, mv_x_o, mv_y_o, mvp_x_o, mvp_y_o,
               res_valid_o, res_mv_x_o, res_mv_y_o, res_cost_o, blk_idx_o, err_o
    );

    modport master (
        output blk_valid_i, blk_mv_x_i, blk_mv_y_i, blk_mvp_x_i, blk_mvp_y_i,
               satd_done_i, cost_valid_i, bcost_i, bcand_x_i, bcand_y_i, res_ready_i,
        input  blk_ready_o, satd_start_o, half_o, mv_x_o, mv_y_o, mvp_x_o, mvp_y_o,
               res_valid_o, res_mv_x_o, res_mv_y_o, res_cost_o, blk_idx_o, err_o
    );
endinterface

// File: rtl/fme_refine_ctrl.sv
// fme_refine_ctrl: sequences half-pel then quarter-pel refinement per partition and hands out the refined MV/cost.
// Ports: clk_i, rst_n_i (async active-low), bus (fme_refine_ctrl_if.slave: IME input, SATD/cost block, result, status).
// Option macro FME_QPEL_EN: defined = half then quarter step; undefined = half step only (half_o stays 1).
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif
module fme_refine_ctrl #(
    parameter int FMVD_LEN  = 8,
    parameter int SATD_BITS = `BIT_DEPTH + 10,
    parameter int NUM_BLK   = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    fme_refine_ctrl_if.slave   bus
);
`ifdef FME_QPEL_EN
    localparam bit QPEL = 1'b1;
`else
    localparam bit QPEL = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, H_REQ, H_WAIT, Q_REQ, Q_WAIT, OUT} state_t;

    state_t              state_q, state_d;
    logic [FMVD_LEN-1:0] mv_x_q, mv_x_d, mv_y_q, mv_y_d, mvp_x_q, mvp_x_d, mvp_y_q, mvp_y_d;
    logic [FMVD_LEN-1:0] res_mv_x_q, res_mv_x_d, res_mv_y_q, res_mv_y_d;
    logic [SATD_BITS:0]  res_cost_q, res_cost_d;
    logic [3:0]          idx_q, idx_d;
    logic                half_q, half_d, err_q, err_d;
    logic                wait_hit, last_hit, accept, handoff;
    logic [FMVD_LEN-1:0] nx, ny;
    logic                unused_satd_done;

    // Saturating mv + dec(c), doubled on the half step; two guard bits detect overflow.
    function automatic logic [FMVD_LEN-1:0] step(input logic [FMVD_LEN-1:0] mv, input logic [1:0] c, input logic dbl);
        logic [1:0]          d;
        logic [2:0]          off;
        logic [FMVD_LEN+1:0] s;
        d   = (c == 2'b01 || c == 2'b11) ? c : 2'b00;
        off = dbl ? {d, 1'b0} : {d[1], d};
        s   = {{2{mv[FMVD_LEN-1]}}, mv} + {{(FMVD_LEN-1){off[2]}}, off};
        return (s[FMVD_LEN+1:FMVD_LEN-1] == 3'b000 || s[FMVD_LEN+1:FMVD_LEN-1] == 3'b111) ? s[FMVD_LEN-1:0]
             : {s[FMVD_LEN+1], {(FMVD_LEN-1){~s[FMVD_LEN+1]}}};
    endfunction

    assign unused_satd_done = bus.satd_done_i;
    assign accept   = state_q == IDLE && bus.blk_valid_i;
    assign handoff  = state_q == OUT && bus.res_ready_i;
    assign wait_hit = (state_q == H_WAIT || state_q == Q_WAIT) && bus.cost_valid_i;
    // Final step is the quarter step, or the half step when quarter refinement is compiled out.
    assign last_hit = wait_hit && (state_q == Q_WAIT || !QPEL);
    assign nx = step(mv_x_q, bus.bcand_x_i, state_q == H_WAIT);
    assign ny = step(mv_y_q, bus.bcand_y_i, state_q == H_WAIT);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.blk_valid_i ? H_REQ : IDLE;
            H_REQ:   state_d = H_WAIT;
            H_WAIT:  state_d = bus.cost_valid_i ? (QPEL ? Q_REQ : OUT) : H_WAIT;
            Q_REQ:   state_d = Q_WAIT;
            Q_WAIT:  state_d = bus.cost_valid_i ? OUT : Q_WAIT;
            OUT:     state_d = bus.res_ready_i ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mv_x_d     = accept ? bus.blk_mv_x_i  : wait_hit ? nx : mv_x_q;
        mv_y_d     = accept ? bus.blk_mv_y_i  : wait_hit ? ny : mv_y_q;
        mvp_x_d    = accept ? bus.blk_mvp_x_i : mvp_x_q;
        mvp_y_d    = accept ? bus.blk_mvp_y_i : mvp_y_q;
        half_d     = accept ? 1'b1 : (wait_hit && QPEL) ? 1'b0 : half_q;
        err_d      = err_q | (wait_hit && (bus.bcand_x_i == 2'b10 || bus.bcand_y_i == 2'b10));
        res_mv_x_d = last_hit ? nx : res_mv_x_q;
        res_mv_y_d = last_hit ? ny : res_mv_y_q;
        res_cost_d = last_hit ? bus.bcost_i : res_cost_q;
        idx_d      = handoff ? ((idx_q == 4'(NUM_BLK - 1)) ? 4'd0 : idx_q + 4'd1) : idx_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mv_x_q     <= '0;
            mv_y_q     <= '0;
            mvp_x_q    <= '0;
            mvp_y_q    <= '0;
            half_q     <= 1'b0;
            err_q      <= 1'b0;
            res_mv_x_q <= '0;
            res_mv_y_q <= '0;
            res_cost_q <= '0;
            idx_q      <= '0;
        end else begin
            mv_x_q     <= mv_x_d;
            mv_y_q     <= mv_y_d;
            mvp_x_q    <= mvp_x_d;
            mvp_y_q    <= mvp_y_d;
            half_q     <= half_d;
            err_q      <= err_d;
            res_mv_x_q <= res_mv_x_d;
            res_mv_y_q <= res_mv_y_d;
            res_cost_q <= res_cost_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        bus.blk_ready_o  = state_q == IDLE;
        bus.satd_start_o = state_q == H_REQ || state_q == Q_REQ;
        bus.res_valid_o  = state_q == OUT;
        bus.half_o       = half_q;
        bus.mv_x_o       = mv_x_q;
        bus.mv_y_o       = mv_y_q;
        bus.mvp_x_o      = mvp_x_q;
        bus.mvp_y_o      = mvp_y_q;
        bus.res_mv_x_o   = res_mv_x_q;
        bus.res_mv_y_o   = res_mv_y_q;
        bus.res_cost_o   = res_cost_q;
        bus.blk_idx_o    = idx_q;
        bus.err_o        = err_q;
    end
endmodule

// File: tb/tb_fme_refine_ctrl.sv
// tb_fme_refine_ctrl: randomized self-checking bench for fme_refine_ctrl against an arithmetic reference model.
module tb_fme_refine_ctrl;
    localparam int N  = 8;
    localparam int SB = 18;
`ifdef FME_QPEL_EN
    localparam bit QPEL = 1'b1;
`else
    localparam bit QPEL = 1'b0;
`endif

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    fme_refine_ctrl_if #(.FMVD_LEN(N), .SATD_BITS(SB)) bus ();
    fme_refine_ctrl #(.FMVD_LEN(N), .SATD_BITS(SB), .NUM_BLK(16)) dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));

    int checks = 0, failures = 0, starts = 0, exp_idx = 0;
    bit exp_err = 1'b0;

    always @(posedge clk_i) if (bus.satd_start_o === 1'b1) starts <= starts + 1;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    function automatic int dec(input logic [1:0] c);
        return c == 2'b01 ? 1 : c == 2'b11 ? -1 : 0;
    endfunction

    function automatic int sat(input int v);
        return v > 127 ? 127 : v < -128 ? -128 : v;
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (bus.blk_ready_o !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("blk_ready", bus.blk_ready_o, 1);
    endtask

    // One refinement step seen from the SATD/cost side: delay, then deliver the winner.
    task automatic respond(input int d, input int cx, input int cy, input bit hf,
                           input logic [1:0] bx, input logic [1:0] by, input int cost);
        for (int i = 0; i < d; i++) begin
            bus.satd_done_i = (i == d - 1);
            tick();
            chk("wait_start_low", bus.satd_start_o, 0);
        end
        bus.satd_done_i = 1'b0;
        chk("stable_mvx", $signed(bus.mv_x_o), cx);
        chk("stable_mvy", $signed(bus.mv_y_o), cy);
        chk("stable_half", bus.half_o, hf);
        bus.cost_valid_i = 1'b1;
        bus.bcand_x_i    = bx;
        bus.bcand_y_i    = by;
        bus.bcost_i      = cost[SB:0];
        tick();
        bus.cost_valid_i = 1'b0;
        bus.bcand_x_i    = 2'($urandom);
        bus.bcand_y_i    = 2'($urandom);
        bus.bcost_i      = (SB+1)'($urandom);
    endtask

    task automatic run(input int mx, input int my, input int px, input int py,
                       input logic [1:0] hx, input logic [1:0] hy, input logic [1:0] qx, input logic [1:0] qy,
                       input int ch, input int cq, input int hd, input int qd, input int rd);
        int ex, ey, ecost, s0;
        wait_ready();
        s0 = starts;
        bus.blk_mv_x_i  = mx[N-1:0];
        bus.blk_mv_y_i  = my[N-1:0];
        bus.blk_mvp_x_i = px[N-1:0];
        bus.blk_mvp_y_i = py[N-1:0];
        bus.blk_valid_i = 1'b1;
        tick();
        bus.blk_valid_i = 1'b0;
        bus.blk_mv_x_i  = N'($urandom);
        bus.blk_mvp_y_i = N'($urandom);
        chk("h_start", bus.satd_start_o, 1);
        chk("h_half", bus.half_o, 1);
        chk("h_mvx", $signed(bus.mv_x_o), mx);
        chk("h_mvy", $signed(bus.mv_y_o), my);
        chk("h_mvpx", $signed(bus.mvp_x_o), px);
        chk("h_mvpy", $signed(bus.mvp_y_o), py);
        chk("busy_ready", bus.blk_ready_o, 0);
        tick();
        chk("h_start_pulse", bus.satd_start_o, 0);
        respond(hd, mx, my, 1'b1, hx, hy, ch);
        ex = sat(mx + 2 * dec(hx));
        ey = sat(my + 2 * dec(hy));
        ecost = ch;
        exp_err |= (hx == 2'b10 || hy == 2'b10);
        if (QPEL) begin
            chk("q_start", bus.satd_start_o, 1);
            chk("q_half", bus.half_o, 0);
            chk("q_mvx", $signed(bus.mv_x_o), ex);
            chk("q_mvy", $signed(bus.mv_y_o), ey);
            tick();
            respond(qd, ex, ey, 1'b0, qx, qy, cq);
            ex = sat(ex + dec(qx));
            ey = sat(ey + dec(qy));
            ecost = cq;
            exp_err |= (qx == 2'b10 || qy == 2'b10);
        end
        for (int r = 0; r <= rd; r++) begin
            chk("res_valid", bus.res_valid_o, 1);
            chk("res_mvx", $signed(bus.res_mv_x_o), ex);
            chk("res_mvy", $signed(bus.res_mv_y_o), ey);
            chk("res_cost", bus.res_cost_o, ecost);
            chk("out_ready", bus.blk_ready_o, 0);
            chk("out_idx", bus.blk_idx_o, exp_idx);
            if (r < rd) tick();
        end
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
        exp_idx = (exp_idx + 1) % 16;
        chk("post_valid", bus.res_valid_o, 0);
        chk("post_ready", bus.blk_ready_o, 1);
        chk("post_idx", bus.blk_idx_o, exp_idx);
        chk("err", bus.err_o, exp_err);
        chk("start_count", starts - s0, QPEL ? 2 : 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, bus.blk_ready_o, 1);
        chk({tag, "_start"}, bus.satd_start_o, 0);
        chk({tag, "_half"}, bus.half_o, 0);
        chk({tag, "_mvx"}, bus.mv_x_o, 0);
        chk({tag, "_valid"}, bus.res_valid_o, 0);
        chk({tag, "_rescost"}, bus.res_cost_o, 0);
        chk({tag, "_idx"}, bus.blk_idx_o, 0);
        chk({tag, "_err"}, bus.err_o, 0);
    endtask

    initial begin
        bus.blk_valid_i  = 1'b0;
        bus.blk_mv_x_i   = '0;
        bus.blk_mv_y_i   = '0;
        bus.blk_mvp_x_i  = '0;
        bus.blk_mvp_y_i  = '0;
        bus.satd_done_i  = 1'b0;
        bus.cost_valid_i = 1'b0;
        bus.bcost_i      = '0;
        bus.bcand_x_i    = '0;
        bus.bcand_y_i    = '0;
        bus.res_ready_i  = 1'b0;
        #3;
        chk_reset_state("rst");
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
        run(8, 8, 0, 0, 2'b01, 2'b11, 2'b11, 2'b00, 300, 300, 1, 2, 0);
        run(-5, 17, 3, -4, 2'b11, 2'b01, 2'b01, 2'b11, 1000, 777, 0, 0, 5);
        run(126, -126, 1, 1, 2'b01, 2'b11, 2'b01, 2'b11, 50, 40, 2, 1, 0);
        run(10, 10, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 60, 70, 1, 1, 1);
        run(-3, 4, 0, 0, 2'b00, 2'b00, 2'b01, 2'b01, 61, 71, 0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            bus.cost_valid_i = 1'b1;
            bus.satd_done_i  = 1'b1;
            bus.bcand_x_i    = 2'b01;
            tick();
            chk("idle_spur_ready", bus.blk_ready_o, 1);
            chk("idle_spur_start", bus.satd_start_o, 0);
            chk("idle_spur_valid", bus.res_valid_o, 0);
        end
        bus.cost_valid_i = 1'b0;
        bus.satd_done_i  = 1'b0;
        run(20, -20, 2, 2, 2'b11, 2'b11, 2'b01, 2'b00, 123, 99, 0, 0, 0);
        wait_ready();
        bus.blk_mv_x_i  = 8'd40;
        bus.blk_valid_i = 1'b1;
        tick();
        bus.blk_valid_i = 1'b0;
        tick();
        #2 rst_n_i = 1'b0;
        #1 chk_reset_state("mid_rst");
        tick();
        rst_n_i = 1'b1;
        exp_idx = 0;
        exp_err = 1'b0;
        tick();
        run(8, 8, 0, 0, 2'b01, 2'b11, 2'b11, 2'b00, 300, 300, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            run(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                int'($urandom_range(0, 262143)), int'($urandom_range(0, 262143)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
